// File: rtl/arb_pkg.sv
// Shared types and constants for the 8-way round-robin arbiter.
// The requester count is fixed at 8, so the 3-bit index helpers below wrap
// modulo 8 simply by truncating to IDX_W bits.
package arb_pkg;

    localparam int NUM_REQ      = 8;
    localparam int IDX_W        = 3;
    localparam int DEF_MAX_HOLD = 16;
    localparam int DEF_CNT_W    = 5;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // Modulo-8 addition of two requester indices.
    function automatic logic [IDX_W-1:0] idx_add(
        input logic [IDX_W-1:0] a,
        input logic [IDX_W-1:0] b
    );
        return a + b;
    endfunction

    // One-hot decode of a requester index.
    function automatic logic [NUM_REQ-1:0] onehot8(input logic [IDX_W-1:0] idx);
        return 8'b0000_0001 << idx;
    endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin selector: rotates the request vector so that
// requester `ptr` sits in position 0, finds the lowest set bit, and maps the
// rotated position back to the real requester index.
import arb_pkg::*;

module rr_pick8 (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               any,
    output logic [IDX_W-1:0]   idx
);

    logic [NUM_REQ-1:0] rot_s;
    logic [IDX_W-1:0]   off_s;
    logic               found_s;

    // Rotate so that rot_s[k] is the request of requester (ptr + k) mod 8.
    always_comb begin
        rot_s = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            rot_s[k] = req[idx_add(IDX_W'(k), ptr)];
        end
    end

    // Fixed-priority find-first-set on the rotated vector (position 0 wins).
    always_comb begin
        off_s   = 3'd0;
        found_s = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (rot_s[k] && !found_s) begin
                found_s = 1'b1;
                off_s   = IDX_W'(k);
            end else begin
                found_s = found_s;
            end
        end
    end

    assign any = found_s;
    assign idx = idx_add(off_s, ptr);

endmodule

// File: rtl/rr_arbiter_8.sv
// 8-requester round-robin arbiter with registered one-hot grant, encoded
// index and a hold timeout. A grant is held until the owner pulses done,
// drops its request, or has held for MAX_HOLD cycles; every release passes
// through one IDLE cycle before the next grant is issued.
import arb_pkg::*;

module rr_arbiter_8 #(
    parameter int MAX_HOLD = DEF_MAX_HOLD,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               done,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_valid,
    output logic               timeout
);

    // Timeout is disabled entirely when MAX_HOLD is 0; the counter then stays at 0.
    localparam bit               LIMIT_EN  = (MAX_HOLD != 0);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD == 0) ? 0 : (MAX_HOLD - 1));
    localparam logic [CNT_W-1:0] CNT_SAT   = {CNT_W{1'b1}};

    arb_state_e         state_q,     state_d;
    logic [IDX_W-1:0]   ptr_q,       ptr_d;
    logic [CNT_W-1:0]   hold_cnt_q,  hold_cnt_d;
    logic [NUM_REQ-1:0] gnt_q,       gnt_d;
    logic [IDX_W-1:0]   gnt_idx_q,   gnt_idx_d;
    logic               gnt_valid_q, gnt_valid_d;
    logic               timeout_q,   timeout_d;

    logic               pick_any_s;
    logic [IDX_W-1:0]   pick_idx_s;
    logic               rel_normal_s;
    logic               rel_limit_s;

    rr_pick8 u_pick (
        .req (req),
        .ptr (ptr_q),
        .any (pick_any_s),
        .idx (pick_idx_s)
    );

    // Release causes while granted: owner-driven (done / request drop) versus hold limit.
    always_comb begin
        rel_normal_s = done | ~req[gnt_idx_q];
        if (LIMIT_EN) begin
            rel_limit_s = (hold_cnt_q == HOLD_LAST);
        end else begin
            rel_limit_s = 1'b0;
        end
    end

    // Next-state and next-output logic for the IDLE/GRANT FSM.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        hold_cnt_d  = hold_cnt_q;
        gnt_d       = gnt_q;
        gnt_idx_d   = gnt_idx_q;
        gnt_valid_d = gnt_valid_q;
        timeout_d   = 1'b0;

        case (state_q)
            IDLE: begin
                // done is deliberately ignored here.
                hold_cnt_d = '0;
                if (pick_any_s) begin
                    state_d     = GRANT;
                    gnt_d       = onehot8(pick_idx_s);
                    gnt_idx_d   = pick_idx_s;
                    gnt_valid_d = 1'b1;
                end else begin
                    gnt_d       = '0;
                    gnt_valid_d = 1'b0;
                end
            end
            GRANT: begin
                if (rel_normal_s || rel_limit_s) begin
                    state_d     = IDLE;
                    gnt_d       = '0;
                    gnt_valid_d = 1'b0;
                    ptr_d       = idx_add(gnt_idx_q, 3'd1);
                    hold_cnt_d  = '0;
                    // Only a release caused purely by the hold limit is a timeout.
                    timeout_d   = rel_limit_s & ~rel_normal_s;
                end else begin
                    // No preemption: the grant stays put whatever other requests do.
                    if (!LIMIT_EN) begin
                        hold_cnt_d = '0;
                    end else if (hold_cnt_q != CNT_SAT) begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end else begin
                        hold_cnt_d = hold_cnt_q;
                    end
                end
            end
            default: begin
                state_d     = IDLE;
                gnt_d       = '0;
                gnt_valid_d = 1'b0;
                hold_cnt_d  = '0;
            end
        endcase
    end

    // State, pointer, counter and output registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= 3'd0;
            hold_cnt_q  <= '0;
            gnt_q       <= 8'd0;
            gnt_idx_q   <= 3'd0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            hold_cnt_q  <= hold_cnt_d;
            gnt_q       <= gnt_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = gnt_idx_q;
    assign gnt_valid = gnt_valid_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Directed bench for rr_arbiter_8: inputs change 1 ns after a rising edge and
// outputs are sampled at that same point, so each sample shows the result of
// the edge just taken.
module tb_rr_arbiter_8;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    int passed;
    int total;

    rr_arbiter_8 #(.MAX_HOLD(16), .CNT_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Full output snapshot against expected grant/index/valid/timeout.
    task automatic chk_all(input string tag, input logic [7:0] eg, input logic [2:0] ei,
                           input logic ev, input logic et);
        chk({tag, ".gnt"},       gnt,               eg);
        chk({tag, ".gnt_idx"},   {5'd0, gnt_idx},   {5'd0, ei});
        chk({tag, ".gnt_valid"}, {7'd0, gnt_valid}, {7'd0, ev});
        chk({tag, ".timeout"},   {7'd0, timeout},   {7'd0, et});
    endtask

    initial begin
        logic [7:0] eg;
        logic [2:0] ei;
        passed = 0;
        total  = 0;
        rst  = 1'b1;
        req  = 8'h00;
        done = 1'b0;
        #3;
        chk_all("reset", 8'h00, 3'd0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;

        // Single requester 2, released by done in cycle 4.
        req = 8'h04;
        tick();
        chk_all("t1.c1", 8'h04, 3'd2, 1'b1, 1'b0);
        tick();
        tick();
        tick();
        chk_all("t1.c4", 8'h04, 3'd2, 1'b1, 1'b0);
        done = 1'b1;
        tick();
        done = 1'b0;
        chk_all("t1.c5", 8'h00, 3'd2, 1'b0, 1'b0);
        // ptr should now be 3: with requests 2 and 3 the winner is 3.
        req = 8'h0C;
        tick();
        chk_all("t1.ptr3", 8'h08, 3'd3, 1'b1, 1'b0);
        done = 1'b1;
        tick();
        done = 1'b0;
        chk_all("t1.rel", 8'h00, 3'd3, 1'b0, 1'b0);

        // All requesting, done each grant: order 4,5,6,7,0,1,2,3,4 with one gap each.
        req = 8'hFF;
        for (int n = 0; n < 9; n++) begin
            ei = 3'((4 + n) % 8);
            eg = 8'h01 << ei;
            tick();
            chk_all("t2.grant", eg, ei, 1'b1, 1'b0);
            done = 1'b1;
            tick();
            done = 1'b0;
            chk_all("t2.gap", 8'h00, ei, 1'b0, 1'b0);
        end

        // Owner 5 drops its request while 1 waits (ptr=5 here).
        req = 8'h22;
        tick();
        chk_all("t3.g5", 8'h20, 3'd5, 1'b1, 1'b0);
        tick();
        chk_all("t3.nopre", 8'h20, 3'd5, 1'b1, 1'b0);
        req = 8'h02;
        tick();
        chk_all("t3.drop", 8'h00, 3'd5, 1'b0, 1'b0);
        tick();
        chk_all("t3.g1", 8'h02, 3'd1, 1'b1, 1'b0);
        req = 8'h00;
        tick();
        chk_all("t3.rel", 8'h00, 3'd1, 1'b0, 1'b0);

        // Hold limit: requester 3 holds exactly 16 cycles, then one timeout pulse.
        req = 8'h08;
        tick();
        chk_all("t4.c1", 8'h08, 3'd3, 1'b1, 1'b0);
        for (int n = 2; n <= 16; n++) begin
            tick();
            chk_all("t4.hold", 8'h08, 3'd3, 1'b1, 1'b0);
        end
        tick();
        chk_all("t4.tmo", 8'h00, 3'd3, 1'b0, 1'b1);
        tick();
        chk_all("t4.regrant", 8'h08, 3'd3, 1'b1, 1'b0);

        // done coinciding with the hold limit: normal release, no timeout.
        for (int n = 2; n <= 16; n++) begin
            tick();
        end
        chk_all("t5.c16", 8'h08, 3'd3, 1'b1, 1'b0);
        done = 1'b1;
        tick();
        done = 1'b0;
        req  = 8'h00;
        chk_all("t5.rel", 8'h00, 3'd3, 1'b0, 1'b0);
        // done in IDLE without requests has no effect.
        done = 1'b1;
        tick();
        chk_all("t5.idle", 8'h00, 3'd3, 1'b0, 1'b0);
        // done in IDLE alongside a request does not block the grant (ptr=4 wraps to 0).
        req = 8'h01;
        tick();
        done = 1'b0;
        chk_all("t5.g0", 8'h01, 3'd0, 1'b1, 1'b0);
        req = 8'h00;
        tick();
        chk_all("t5.rel0", 8'h00, 3'd0, 1'b0, 1'b0);

        // Serve 6 once (ptr becomes 7), grant 6 again, then reset mid-grant.
        req = 8'h40;
        tick();
        chk_all("t6.g6a", 8'h40, 3'd6, 1'b1, 1'b0);
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        chk_all("t6.g6b", 8'h40, 3'd6, 1'b1, 1'b0);
        req = 8'hC0;
        #2;
        rst = 1'b1;
        #1;
        chk_all("t6.async", 8'h00, 3'd0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        chk_all("t6.ptr0", 8'h40, 3'd6, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
